// File: rtl/mem_dump_pkg.sv
// mem_dump_pkg
// Shared definitions for the memory dump block: byte/word geometry and the
// sequencing FSM state encoding.
package mem_dump_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_W         = 8;
    localparam int WORD_W         = BYTES_PER_WORD * BYTE_W;
    localparam int IDX_W          = $clog2(BYTES_PER_WORD);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_READ = 3'd1,
        ST_WAIT = 3'd2,
        ST_LOAD = 3'd3,
        ST_SEND = 3'd4,
        ST_DONE = 3'd5
    } dump_state_t;

endpackage

// File: rtl/mem_dump_word_serializer.sv
// word_serializer
// Holds one memory word and hands it out byte by byte (byte 0 first) over a
// valid/ready handshake. tx_data/tx_valid come straight from flops.
// Ports:
//   clk, reset     clock, async active-low reset
//   capture, word  latch a new word into the shift register, byte index -> 0
//   launch         present byte 0 on the next cycle
//   tx_ready       downstream accept
//   tx_data        byte on offer
//   tx_valid       tx_data holds a byte
//   last_xfer      the final byte of the word is transferring this cycle
module word_serializer
    import mem_dump_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              capture,
    input  logic [WORD_W-1:0] word,
    input  logic              launch,
    input  logic              tx_ready,
    output logic [BYTE_W-1:0] tx_data,
    output logic              tx_valid,
    output logic              last_xfer
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

    logic [WORD_W-1:0] shift_q;
    logic [IDX_W-1:0]  idx_q;
    logic              xfer;

    assign xfer      = tx_valid && tx_ready;
    assign last_xfer = xfer && (idx_q == LAST_IDX);

    // The shift register always holds the bytes not yet put on tx_data, so
    // the next byte is simply its low byte.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_q  <= '0;
            idx_q    <= '0;
            tx_valid <= 1'b0;
            tx_data  <= '0;
        end else if (capture) begin
            shift_q <= word;
            idx_q   <= '0;
        end else if (launch) begin
            tx_valid <= 1'b1;
            tx_data  <= shift_q[BYTE_W-1:0];
            shift_q  <= shift_q >> BYTE_W;
        end else if (xfer) begin
            if (idx_q == LAST_IDX) begin
                tx_valid <= 1'b0;
            end else begin
                idx_q   <= idx_q + IDX_W'(1);
                tx_data <= shift_q[BYTE_W-1:0];
                shift_q <= shift_q >> BYTE_W;
            end
        end
    end

endmodule

// File: rtl/mem_dump.sv
// mem_dump
// Sweeps data memory words 0..num_words-1 and streams each word to a UART
// transmitter as 4 bytes, little-endian.
// Ports:
//   clk, reset      clock, async active-low reset
//   start           request a sweep (sampled in IDLE only)
//   mem_rd/mem_addr read strobe and word address to data memory
//   mem_rd_data     read data, valid the cycle after mem_rd
//   tx_data/valid   byte stream toward the transmitter
//   tx_ready        transmitter accept
//   busy            sweep in progress
//   done            one-cycle pulse after the last byte transferred
//
// state | meaning
// IDLE  | waiting for start
// READ  | mem_rd strobe for the word at mem_addr
// WAIT  | RAM latency cycle; read data is captured at its end
// LOAD  | serializer puts byte 0 on the bus
// SEND  | bytes handed out under valid/ready
// DONE  | done pulse, back to IDLE
module mem_dump
    import mem_dump_pkg::*;
#(
    parameter int len_data  = 32,
    parameter int len_addr  = 11,
    parameter int num_words = 2048
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    output logic                mem_rd,
    output logic [len_addr-1:0] mem_addr,
    input  logic [len_data-1:0] mem_rd_data,
    output logic [BYTE_W-1:0]   tx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    output logic                busy,
    output logic                done
);

    localparam logic [len_addr-1:0] LAST_ADDR = len_addr'(num_words - 1);

    dump_state_t       state;
    dump_state_t       state_next;
    logic              last_xfer;
    logic              mem_rd_d;
    logic              busy_d;
    logic              done_d;
    logic [WORD_W-1:0] word;

    assign word = WORD_W'(mem_rd_data);

    // State register, word counter and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            mem_addr <= '0;
            mem_rd   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state  <= state_next;
            mem_rd <= mem_rd_d;
            busy   <= busy_d;
            done   <= done_d;
            if (state == ST_IDLE && start) begin
                mem_addr <= '0;
            end else if (state == ST_SEND && last_xfer && mem_addr != LAST_ADDR) begin
                mem_addr <= mem_addr + len_addr'(1);
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start) state_next = ST_READ;
            ST_READ: state_next = ST_WAIT;
            ST_WAIT: state_next = ST_LOAD;
            ST_LOAD: state_next = ST_SEND;
            ST_SEND: begin
                if (last_xfer) begin
                    state_next = (mem_addr == LAST_ADDR) ? ST_DONE : ST_READ;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered above, so they
    // line up with the state they describe.
    always_comb begin
        mem_rd_d = (state_next == ST_READ);
        done_d   = (state_next == ST_DONE);
        busy_d   = (state_next == ST_READ) || (state_next == ST_WAIT) ||
                   (state_next == ST_LOAD) || (state_next == ST_SEND);
    end

    word_serializer u_ser (
        .clk       (clk),
        .reset     (reset),
        .capture   (state == ST_WAIT),
        .word      (word),
        .launch    (state == ST_LOAD),
        .tx_ready  (tx_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .last_xfer (last_xfer)
    );

endmodule
